sdram_arb: RTL and testbench

SDRAM_ARB -- requirements
Module: sdram_arb

---
 rtl/sdram_arb_pkg.sv | 28 ++
 rtl/sdram_arb_if.sv | 45 ++++
 rtl/sdram_arb.sv | 146 ++++++++++++++
 tb/tb_sdram_arb.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_arb_pkg.sv
// Shared types and constants for the two-requester SDRAM arbiter.
// Holds the state encoding, default watchdog/error values and bus widths.
package sdram_arb_pkg;

  localparam int ADDR_W = 22;
  localparam int DATA_W = 32;

  localparam int                TIMEOUT_DEF  = 255;
  localparam logic [DATA_W-1:0] ERR_DATA_DEF = 32'hffff_ffff;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_ACK   = 2'd3;

  typedef enum logic {
    GNT_A = 1'b0,
    GNT_B = 1'b1
  } grant_e;

  // Wait counter is at least 8 bits wide, wider if TIMEOUT needs it.
  function automatic int cnt_width(input int timeout);
    int w;
    w = $clog2(timeout + 1);
    return (w < 8) ? 8 : w;
  endfunction

endpackage

// File: rtl/sdram_arb_if.sv
// Requester A/B and SDRAM controller signals of the arbiter; slave is the arbiter side.
// The master modport is the environment that drives requests and answers commands.
interface sdram_arb_if;
  import sdram_arb_pkg::*;

  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_datain;
  logic              a_write;
  logic              a_req;
  logic              a_ack;
  logic [DATA_W-1:0] a_dataout;

  logic [ADDR_W-1:0] b_addr;
  logic              b_req;
  logic              b_ack;
  logic [DATA_W-1:0] b_dataout;

  logic [ADDR_W-1:0] sdram_addr;
  logic [DATA_W-1:0] sdram_data_out;
  logic              sdram_write;
  logic              sdram_req;
  logic              sdram_ready;
  logic              sdram_done;
  logic [DATA_W-1:0] sdram_data_in;
  logic              sdram_timeout;

  modport slave (
    input  a_addr, a_datain, a_write, a_req,
    output a_ack, a_dataout,
    input  b_addr, b_req,
    output b_ack, b_dataout,
    output sdram_addr, sdram_data_out, sdram_write, sdram_req, sdram_timeout,
    input  sdram_ready, sdram_done, sdram_data_in
  );

  modport master (
    output a_addr, a_datain, a_write, a_req,
    input  a_ack, a_dataout,
    output b_addr, b_req,
    input  b_ack, b_dataout,
    input  sdram_addr, sdram_data_out, sdram_write, sdram_req, sdram_timeout,
    output sdram_ready, sdram_done, sdram_data_in
  );

endinterface

// File: rtl/sdram_arb.sv
// Round-robin arbiter of requesters A (r/w) and B (read-only) onto one SDRAM port; req->sdram_req 1 cycle, ack 1 cycle after done.
// Stalls in IDLE while sdram_ready is low; a watchdog ends a WAIT with ERR_DATA if done never comes.
module sdram_arb
  import sdram_arb_pkg::*;
#(
  parameter int                TIMEOUT  = TIMEOUT_DEF,
  parameter logic [DATA_W-1:0] ERR_DATA = ERR_DATA_DEF
) (
  input logic        clk,
  input logic        reset,
  sdram_arb_if.slave bus
);

  localparam int               CNT_W    = cnt_width(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [1:0]        state_q, state_d;
  grant_e            grant_q, grant_d;
  grant_e            last_q, last_d;
  logic              just_acked_q, just_acked_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              write_q, write_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] a_dout_q, a_dout_d;
  logic [DATA_W-1:0] b_dout_q, b_dout_d;
  logic              timeout_q, timeout_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic   a_eff;
  logic   b_eff;
  grant_e win;

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_d       = last_q;
    just_acked_d = 1'b0;
    addr_d       = addr_q;
    write_d      = write_q;
    wdata_d      = wdata_q;
    a_dout_d     = a_dout_q;
    b_dout_d     = b_dout_q;
    timeout_d    = timeout_q;
    cnt_d        = cnt_q;
    win          = GNT_A;

    // The requester just acked may still show req for one cycle; ignore it then.
    a_eff = bus.a_req & ~(just_acked_q & (grant_q == GNT_A));
    b_eff = bus.b_req & ~(just_acked_q & (grant_q == GNT_B));

    if (a_eff && b_eff) begin
      win = (last_q == GNT_B) ? GNT_A : GNT_B;
    end else if (b_eff) begin
      win = GNT_B;
    end

    case (state_q)
      ST_IDLE: begin
        if ((a_eff || b_eff) && bus.sdram_ready) begin
          grant_d = win;
          state_d = ST_ISSUE;
          if (win == GNT_A) begin
            addr_d  = bus.a_addr;
            write_d = bus.a_write;
            wdata_d = bus.a_datain;
          end else begin
            addr_d  = bus.b_addr;
            write_d = 1'b0;
            wdata_d = '0;
          end
        end
      end

      ST_ISSUE: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end

      ST_WAIT: begin
        if (bus.sdram_done) begin
          state_d = ST_ACK;
          if (!write_q) begin
            if (grant_q == GNT_A) a_dout_d = bus.sdram_data_in;
            else                  b_dout_d = bus.sdram_data_in;
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d   = ST_ACK;
          timeout_d = 1'b1;
          if (!write_q) begin
            if (grant_q == GNT_A) a_dout_d = ERR_DATA;
            else                  b_dout_d = ERR_DATA;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_ACK: begin
        last_d       = grant_q;
        just_acked_d = 1'b1;
        state_d      = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      grant_q      <= GNT_A;
      last_q       <= GNT_B;
      just_acked_q <= 1'b0;
      addr_q       <= '0;
      write_q      <= 1'b0;
      wdata_q      <= '0;
      a_dout_q     <= '0;
      b_dout_q     <= '0;
      timeout_q    <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_q       <= last_d;
      just_acked_q <= just_acked_d;
      addr_q       <= addr_d;
      write_q      <= write_d;
      wdata_q      <= wdata_d;
      a_dout_q     <= a_dout_d;
      b_dout_q     <= b_dout_d;
      timeout_q    <= timeout_d;
      cnt_q        <= cnt_d;
    end
  end

  assign bus.sdram_req      = (state_q == ST_ISSUE);
  assign bus.sdram_addr     = addr_q;
  assign bus.sdram_write    = write_q;
  assign bus.sdram_data_out = wdata_q;
  assign bus.sdram_timeout  = timeout_q;
  assign bus.a_ack          = (state_q == ST_ACK) && (grant_q == GNT_A);
  assign bus.b_ack          = (state_q == ST_ACK) && (grant_q == GNT_B);
  assign bus.a_dataout      = a_dout_q;
  assign bus.b_dataout      = b_dout_q;

endmodule

// File: tb/tb_sdram_arb.sv
// Directed plus randomized bench for sdram_arb; the bench plays both requesters and the SDRAM controller.
// Expected grants and read data come from a transaction-level round-robin/watchdog model.
module tb_sdram_arb;
  import sdram_arb_pkg::*;

  localparam int          TO  = 255;
  localparam logic [31:0] ERR = 32'hffff_ffff;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  sdram_arb_if bus();

  sdram_arb #(.TIMEOUT(TO), .ERR_DATA(ERR)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Model state: last winner (0=A, 1=B), each requester's visible read data, sticky timeout.
  bit          last_m;
  logic [31:0] a_m, b_m;
  bit          to_m;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    last_m = 1'b1;
    a_m    = '0;
    b_m    = '0;
    to_m   = 1'b0;
  endtask

  task automatic check_reset_outputs(input string ctx);
    chk({ctx, "_a_ack"},     32'(bus.a_ack), 32'd0);
    chk({ctx, "_b_ack"},     32'(bus.b_ack), 32'd0);
    chk({ctx, "_sdram_req"}, 32'(bus.sdram_req), 32'd0);
    chk({ctx, "_sdram_wr"},  32'(bus.sdram_write), 32'd0);
    chk({ctx, "_sdram_adr"}, 32'(bus.sdram_addr), 32'd0);
    chk({ctx, "_sdram_dat"}, bus.sdram_data_out, 32'd0);
    chk({ctx, "_a_dout"},    bus.a_dataout, a_m);
    chk({ctx, "_b_dout"},    bus.b_dataout, b_m);
    chk({ctx, "_timeout"},   32'(bus.sdram_timeout), 32'(to_m));
    chk({ctx, "_state"},     32'(dut.state_q), 32'(ST_IDLE));
  endtask

  // Serve the given requests to completion; d = done delay after sdram_req (0 = never).
  task automatic run_pair(input bit ra, input bit rb, input int d, input logic [31:0] rd, input bit hold);
    bit          pa, pb, w, got, first, early, tmo, wr;
    int          waited, lim;
    logic [31:0] rdw, exp_addr;
    pa = ra;
    pb = rb;
    first = 1'b1;
    bus.a_req = ra;
    bus.b_req = rb;
    while (pa || pb) begin
      w = (pa && pb) ? !last_m : (pb && !pa);
      got = 1'b0;
      waited = 0;
      for (int t = 0; t < 40 && !got; t++) begin
        tick();
        waited++;
        got = bus.sdram_req;
      end
      chk("grant_seen", 32'(got), 32'd1);
      if (!got) begin
        bus.a_req = 1'b0;
        bus.b_req = 1'b0;
        return;
      end
      if (first) chk("grant_latency", 32'(waited), 32'd1);
      wr = !w && bus.a_write;
      exp_addr = w ? 32'(bus.b_addr) : 32'(bus.a_addr);
      chk("sdram_addr", 32'(bus.sdram_addr), exp_addr);
      chk("sdram_write", 32'(bus.sdram_write), 32'(wr));
      if (wr) chk("sdram_wdata", bus.sdram_data_out, bus.a_datain);

      tmo = (d < 1) || (d > TO);
      lim = tmo ? TO : d;
      rdw = w ? ~rd : rd;
      early = 1'b0;
      for (int i = 1; i <= lim + 1; i++) begin
        tick();
        bus.sdram_done = (i == d);
        if (i == d) bus.sdram_data_in = rdw;
        if (i == 1) chk("req_one_cycle", 32'(bus.sdram_req), 32'd0);
        if (i <= lim && (bus.a_ack || bus.b_ack)) early = 1'b1;
      end
      chk("early_ack", 32'(early), 32'd0);
      chk("a_ack", 32'(bus.a_ack), 32'(!w));
      chk("b_ack", 32'(bus.b_ack), 32'(w));
      chk("addr_held", 32'(bus.sdram_addr), exp_addr);

      if (!wr) begin
        if (w) b_m = tmo ? ERR : rdw;
        else   a_m = tmo ? ERR : rdw;
      end
      to_m   = to_m | tmo;
      last_m = w;
      chk("a_dataout", bus.a_dataout, a_m);
      chk("b_dataout", bus.b_dataout, b_m);
      chk("timeout_flag", 32'(bus.sdram_timeout), 32'(to_m));

      tick();
      bus.sdram_done = 1'b0;
      chk("ack_one_cycle", 32'(bus.a_ack || bus.b_ack), 32'd0);
      if (hold) begin
        tick();
        chk("no_regrant", 32'(bus.sdram_req), 32'd0);
      end
      if (w) begin
        pb = 1'b0;
        bus.b_req = 1'b0;
      end else begin
        pa = 1'b0;
        bus.a_req = 1'b0;
      end
      first = 1'b0;
    end
    tick();
    chk("idle_after", 32'(bus.sdram_req), 32'd0);
  endtask

  initial begin
    bit got, early, ra, rb;
    bus.a_addr        = '0;
    bus.a_datain      = '0;
    bus.a_write       = 1'b0;
    bus.a_req         = 1'b0;
    bus.b_addr        = '0;
    bus.b_req         = 1'b0;
    bus.sdram_ready   = 1'b1;
    bus.sdram_done    = 1'b0;
    bus.sdram_data_in = '0;

    reset = 1'b0;
    repeat (3) tick();
    model_reset();
    check_reset_outputs("reset");
    reset = 1'b1;
    tick();

    // Basic read, then a write that must not disturb a_dataout.
    bus.a_addr = 22'o1234;
    bus.a_write = 1'b0;
    run_pair(1'b1, 1'b0, 3, 32'h0badf00d, 1'b0);
    chk("read_0badf00d", bus.a_dataout, 32'h0badf00d);
    bus.a_addr = 22'o100;
    bus.a_write = 1'b1;
    bus.a_datain = 32'h1234_5678;
    run_pair(1'b1, 1'b0, 2, $urandom, 1'b0);
    bus.a_write = 1'b0;

    // Stray done while idle.
    bus.sdram_done = 1'b1;
    bus.sdram_data_in = 32'hdead_beef;
    tick();
    bus.sdram_done = 1'b0;
    chk("stray_idle_ack", 32'(bus.a_ack || bus.b_ack), 32'd0);
    tick();
    chk("stray_idle_state", 32'(dut.state_q), 32'(ST_IDLE));
    chk("stray_idle_a_dout", bus.a_dataout, a_m);

    // Fresh reset so that simultaneous requests start from last_grant=B.
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    model_reset();
    tick();
    for (int k = 0; k < 2; k++) begin
      bus.a_addr = 22'($urandom);
      bus.b_addr = 22'($urandom);
      run_pair(1'b1, 1'b1, 1 + int'($urandom_range(3)), $urandom, 1'b0);
    end

    // A holds req through the cycle after its ack: must not be re-granted.
    bus.a_addr = 22'($urandom);
    run_pair(1'b1, 1'b0, 2, $urandom, 1'b1);

    // done on the last watchdog cycle wins; then a true timeout; then a late done.
    bus.b_addr = 22'($urandom);
    run_pair(1'b0, 1'b1, TO, $urandom, 1'b0);
    bus.b_addr = 22'($urandom);
    run_pair(1'b0, 1'b1, 0, $urandom, 1'b0);
    bus.a_addr = 22'($urandom);
    run_pair(1'b1, 1'b0, TO + 1, $urandom, 1'b0);

    // Controller busy: no grant until ready.
    bus.sdram_ready = 1'b0;
    bus.a_addr = 22'($urandom);
    bus.a_req = 1'b1;
    early = 1'b0;
    repeat (10) begin
      tick();
      if (bus.sdram_req) early = 1'b1;
    end
    chk("stall_no_req", 32'(early), 32'd0);
    bus.sdram_ready = 1'b1;
    run_pair(1'b1, 1'b0, 4, $urandom, 1'b0);

    for (int k = 0; k < 40; k++) begin
      ra = 1'($urandom);
      rb = ra ? 1'($urandom) : 1'b1;
      bus.a_addr   = 22'($urandom);
      bus.b_addr   = 22'($urandom);
      bus.a_write  = 1'($urandom);
      bus.a_datain = $urandom;
      run_pair(ra, rb, 1 + int'($urandom_range(5)), $urandom, 1'b0);
    end
    bus.a_write = 1'b0;

    // Reset while waiting on the controller, then a stray done.
    bus.a_addr = 22'o7777;
    bus.a_req = 1'b1;
    got = 1'b0;
    for (int t = 0; t < 40 && !got; t++) begin
      tick();
      got = bus.sdram_req;
    end
    chk("rst_wait_grant", 32'(got), 32'd1);
    tick();
    tick();
    reset = 1'b0;
    tick();
    tick();
    bus.a_req = 1'b0;
    reset = 1'b1;
    model_reset();
    tick();
    bus.sdram_done = 1'b1;
    bus.sdram_data_in = 32'hcafe_f00d;
    tick();
    bus.sdram_done = 1'b0;
    early = 1'b0;
    repeat (4) begin
      if (bus.a_ack || bus.b_ack) early = 1'b1;
      tick();
    end
    chk("rst_wait_no_ack", 32'(early), 32'd0);
    check_reset_outputs("rst_wait");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
